// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32 funct3
// width codes and the request legality check used at capture time.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MRG,
        S_WR,
        S_EXT,
        S_ERR
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // High when the request cannot be executed: unknown width code or an
    // address that is not naturally aligned for the access size.
    function automatic logic reqIllegal(input logic isStore, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic badCode;
        logic misaligned;
        if (isStore) begin
            badCode = !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
        end else begin
            badCode = !((f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                        (f3 == F3_LBU) || (f3 == F3_LHU));
        end
        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        return badCode || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extracts and extends load data from a RAM word, and merges
// sub-word store data into the RAM word for read-modify-write stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] ramData,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedData
);

    logic [31:0] shifted;

    always_comb begin
        shifted = ramData >> {byteOff, 3'b000};
        case (funct3)
            F3_LB:   loadData = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   loadData = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  loadData = {24'b0, shifted[7:0]};
            F3_LHU:  loadData = {16'b0, shifted[15:0]};
            default: loadData = shifted;
        endcase

        mergedData = ramData;
        case (funct3[1:0])
            2'b00:   mergedData[{byteOff, 3'b000} +: 8] = storeData[7:0];
            2'b01:   mergedData[{byteOff[1], 4'b0000} +: 16] = storeData[15:0];
            default: mergedData = storeData;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: captures one CPU request, sequences the single-port RAM
// (read, merge, write) and reports completion with an optional error flag.
module lsu
    import lsu_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        ramR,
    output logic        ramW,
    output logic [31:0] ramAddr,
    output logic [31:0] ramDataW,
    input  logic [31:0] ramDataR
);

    state_e        state_q, state_d;
    logic [AW+1:0] addr_q;
    logic [2:0]    f3_q;
    logic          wr_q;
    logic [31:0]   data_q;
    logic [31:0]   rdata_q;
    logic [31:0]   loadData;
    logic [31:0]   mergedData;
    logic          accept;
    logic          unusedAddrBits;

    assign accept         = (state_q == S_IDLE) && req;
    assign unusedAddrBits = ^addr[31:AW+2];

    lsu_align u_align (
        .funct3     (f3_q),
        .byteOff    (addr_q[1:0]),
        .ramData    (ramDataR),
        .storeData  (data_q),
        .loadData   (loadData),
        .mergedData (mergedData)
    );

    // data_q carries the store word: raw wdata for SW, replaced by the merged word in MRG.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= addr[AW+1:0];
                f3_q   <= funct3;
                wr_q   <= wr;
                data_q <= wdata;
            end
            if (state_q == S_MRG) data_q <= mergedData;
            if (state_q == S_EXT) rdata_q <= loadData;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        err     = 1'b0;
        ramR    = 1'b0;
        ramW    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (reqIllegal(wr, funct3, addr[1:0])) state_d = S_ERR;
                    else if (wr && (funct3 == F3_SW))      state_d = S_WR;
                    else                                   state_d = S_RD;
                end
            end
            S_RD: begin
                ramR    = 1'b1;
                state_d = wr_q ? S_MRG : S_EXT;
            end
            S_MRG: state_d = S_WR;
            S_WR: begin
                ramW    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_EXT: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdata    = rdata_q;
    assign ramAddr  = {{(32-AW){1'b0}}, addr_q[AW+1:2]};
    assign ramDataW = data_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a registered RAM model, a shadow memory model
// for expected store results, and a scoreboard queue of per-operation expectations.
module tb_lsu;
    import lsu_pkg::*;

    localparam int AW = 5;

    logic        clock    = 1'b0;
    logic        nReset   = 1'b0;
    logic        req      = 1'b0;
    logic        wr       = 1'b0;
    logic [2:0]  funct3   = '0;
    logic [31:0] addr     = '0;
    logic [31:0] wdata    = '0;
    logic [31:0] ramDataR = '0;
    logic        busy, done, err, ramR, ramW;
    logic [31:0] rdata, ramAddr, ramDataW;

    logic [31:0] mem   [32] = '{5: 32'h8001_F00F, default: 32'h0};
    logic [31:0] model [32] = '{5: 32'h8001_F00F, default: 32'h0};

    typedef struct {
        int          lat;
        logic        e;
        int          nR;
        int          nW;
        logic [31:0] wAddr;
        logic [31:0] wData;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] lastRd     = '0;

    int          oLat, oR, oW, oOverlap;
    logic        oErr;
    logic [31:0] oWAddr, oWData, oRd;

    lsu #(.AW(AW)) dut (
        .clock    (clock),
        .nReset   (nReset),
        .req      (req),
        .wr       (wr),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .ramR     (ramR),
        .ramW     (ramW),
        .ramAddr  (ramAddr),
        .ramDataW (ramDataW),
        .ramDataR (ramDataR)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ramR) ramDataR <= mem[ramAddr[AW-1:0]];
        if (ramW) mem[ramAddr[AW-1:0]] <= ramDataW;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one request for a single cycle, then observes up to 8 cycles for done.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clock);
        req = 1'b1; wr = w; funct3 = f3; addr = a; wdata = d;
        @(posedge clock);
        #1;
        req = 1'b0; wr = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        oLat = -1; oR = 0; oW = 0; oOverlap = 0; oErr = 1'b0; oWAddr = '0; oWData = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (ramR) oR++;
            if (ramW) begin oW++; oWAddr = ramAddr; oWData = ramDataW; end
            if (ramR && ramW) oOverlap++;
            if (done) begin oLat = c; oErr = err; break; end
        end
        @(negedge clock);
        oRd = rdata;
    endtask

    task automatic test_reset();
        #2;
        compared++;
        if ({busy, done, err, ramR, ramW} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, done, err, ramR, ramW});
        end
        compared++;
        if ({rdata, ramDataW, ramAddr} !== 96'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got rdata=%h wdat=%h addr=%h expected zeros",
                     rdata, ramDataW, ramAddr);
        end
        @(negedge clock);
        nReset = 1'b1;
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] expRd);
        exp_t e;
        sb.push_back('{lat: 2, e: 1'b0, nR: 1, nW: 0, wAddr: 32'h0, wData: 32'h0, rd: expRd});
        issue(1'b0, f3, a, 32'hFFFF_FFFF);
        e = sb.pop_front();
        lastRd = e.rd;
        compared++;
        if ((oLat !== e.lat) || (oErr !== e.e)) begin
            mismatched++;
            $display("[TB] FAIL %s done: got cycle %0d err %b expected cycle %0d err %b",
                     name, oLat, oErr, e.lat, e.e);
        end
        compared++;
        if ((oR !== e.nR) || (oW !== e.nW) || (oOverlap !== 0)) begin
            mismatched++;
            $display("[TB] FAIL %s ram: got ramR=%0d ramW=%0d both=%0d expected %0d %0d 0",
                     name, oR, oW, oOverlap, e.nR, e.nW);
        end
        compared++;
        if (oRd !== e.rd) begin
            mismatched++;
            $display("[TB] FAIL %s rdata: got %h expected %h", name, oRd, e.rd);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d);
        exp_t        e;
        logic [31:0] w;
        int          idx;
        idx = int'(a[6:2]);
        w = model[idx];
        if (f3 == F3_SB)      w[8*a[1:0] +: 8]   = d[7:0];
        else if (f3 == F3_SH) w[16*a[1] +: 16]   = d[15:0];
        else                  w                  = d;
        model[idx] = w;
        if (f3 == F3_SW)
            sb.push_back('{lat: 1, e: 1'b0, nR: 0, nW: 1, wAddr: {27'b0, a[6:2]}, wData: w, rd: lastRd});
        else
            sb.push_back('{lat: 3, e: 1'b0, nR: 1, nW: 1, wAddr: {27'b0, a[6:2]}, wData: w, rd: lastRd});
        issue(1'b1, f3, a, d);
        e = sb.pop_front();
        compared++;
        if ((oLat !== e.lat) || (oErr !== e.e)) begin
            mismatched++;
            $display("[TB] FAIL %s done: got cycle %0d err %b expected cycle %0d err %b",
                     name, oLat, oErr, e.lat, e.e);
        end
        compared++;
        if ((oR !== e.nR) || (oW !== e.nW) || (oOverlap !== 0)) begin
            mismatched++;
            $display("[TB] FAIL %s ram: got ramR=%0d ramW=%0d both=%0d expected %0d %0d 0",
                     name, oR, oW, oOverlap, e.nR, e.nW);
        end
        compared++;
        if ((oWAddr !== e.wAddr) || (oWData !== e.wData)) begin
            mismatched++;
            $display("[TB] FAIL %s write: got addr %h data %h expected addr %h data %h",
                     name, oWAddr, oWData, e.wAddr, e.wData);
        end
        compared++;
        if (oRd !== e.rd) begin
            mismatched++;
            $display("[TB] FAIL %s rdata_hold: got %h expected %h", name, oRd, e.rd);
        end
    endtask

    task automatic test_error(input string name, input logic w, input logic [2:0] f3,
                              input logic [31:0] a);
        exp_t e;
        sb.push_back('{lat: 1, e: 1'b1, nR: 0, nW: 0, wAddr: 32'h0, wData: 32'h0, rd: lastRd});
        issue(w, f3, a, 32'h5A5A_5A5A);
        e = sb.pop_front();
        compared++;
        if ((oLat !== e.lat) || (oErr !== e.e)) begin
            mismatched++;
            $display("[TB] FAIL %s done: got cycle %0d err %b expected cycle %0d err %b",
                     name, oLat, oErr, e.lat, e.e);
        end
        compared++;
        if ((oR !== 0) || (oW !== 0) || (oRd !== e.rd)) begin
            mismatched++;
            $display("[TB] FAIL %s side_effects: got ramR=%0d ramW=%0d rdata %h expected 0 0 %h",
                     name, oR, oW, oRd, e.rd);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] d;
        for (int off = 0; off < 4; off++) begin
            d = $urandom;
            test_store("sb_lane", F3_SB, 32'd12 + off, d);
            test_load("lb_lane", F3_LB, 32'd12 + off, {{24{d[7]}}, d[7:0]});
        end
        d = $urandom;
        test_store("sh_upper", F3_SH, 32'd14, d);
        test_load("lhu_upper", F3_LHU, 32'd14, {16'b0, d[15:0]});
        test_load("lw_word3", F3_LW, 32'd12, model[3]);
    endtask

    task automatic test_reset_mid();
        int wSeen = 0;
        @(negedge clock);
        req = 1'b1; wr = 1'b1; funct3 = F3_SH; addr = 32'd20; wdata = 32'h0000_7777;
        @(posedge clock);
        #1;
        req = 1'b0; wr = 1'b0;
        @(negedge clock);
        if (ramW) wSeen++;
        @(negedge clock);
        if (ramW) wSeen++;
        nReset = 1'b0;
        #1;
        lastRd = '0;
        compared++;
        if ({busy, done, ramW, ramR} !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_ctrl: got busy/done/ramW/ramR %b expected 0000",
                     {busy, done, ramW, ramR});
        end
        compared++;
        if ({rdata, ramAddr} !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_data: got rdata %h ramAddr %h expected zeros", rdata, ramAddr);
        end
        @(negedge clock);
        if (ramW) wSeen++;
        nReset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (ramW) wSeen++;
        end
        compared++;
        if ((wSeen !== 0) || (mem[5] !== model[5]) || (busy !== 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_abort: got writes %0d word5 %h busy %b expected 0 %h 0",
                     wSeen, mem[5], busy, model[5]);
        end
    endtask

    task automatic test_back_to_back();
        int nDone = 0;
        int nRd   = 0;
        @(negedge clock);
        req = 1'b1; wr = 1'b0; funct3 = F3_LW; addr = 32'd8;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clock);
            if (i == 12) begin #1; req = 1'b0; end
            @(negedge clock);
            if (done) nDone++;
            if (ramR) nRd++;
        end
        lastRd = model[2];
        compared++;
        if ((nDone !== 4) || (nRd !== 4)) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_count: got done %0d ramR %0d expected 4 4", nDone, nRd);
        end
        compared++;
        if (rdata !== lastRd) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_rdata: got %h expected %h", rdata, lastRd);
        end
    endtask

    initial begin
        $display("[TB] starting lsu bench");
        test_reset();
        test_load("lb_21", F3_LB, 32'd21, 32'hFFFF_FFF0);
        test_load("lbu_21", F3_LBU, 32'd21, 32'h0000_00F0);
        test_load("lh_22", F3_LH, 32'd22, 32'hFFFF_8001);
        test_load("lhu_22", F3_LHU, 32'd22, 32'h0000_8001);
        test_store("sb_20", F3_SB, 32'd20, 32'h1234_56AA);
        test_load("lw_20", F3_LW, 32'd20, 32'h8001_F0AA);
        test_store("sw_8", F3_SW, 32'd8, 32'hDEAD_BEEF);
        test_error("lw_22", 1'b0, F3_LW, 32'd22);
        test_error("sh_21", 1'b1, F3_SH, 32'd21);
        test_error("ld_011", 1'b0, 3'b011, 32'd20);
        test_error("st_100", 1'b1, 3'b100, 32'd20);
        test_lanes();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
